vlc_tail_seq: RTL and testbench
===============================

# vlc_tail_seq

Parametrised sequential tail-lamp controller for the vehicle lighting path: drives LAMPS lamps per side with a Thunderbird-style progressive turn sequence, a synchronous hazard flash and a brake overlay. A built-in prescaler sets the step rate. The block sits between the driver-input pins and the lamp output pins of the VLC top level, and generalises the fixed 3-lamp left/right/emergency controller to any lamp count, step rate and brake mode.

## Interface
- LAMPS, 3, lamps per side; legal range 2..8; bit 0 is the innermost lamp.
- STEP_DIV, 4, clock cycles per sequence step; legal range 1..65535.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; one clock domain, no other reset.
- turn_left  input  1  left turn request (level).
- turn_right  input  1  right turn request (level).
- emergency  input  1  hazard request (level).
- brake  input  1  brake pedal (level).
- left_lamp  output  LAMPS  left lamp drive, 1 = lit.
- right_lamp  output  LAMPS  right lamp drive, 1 = lit.
- mode  output  2  current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

## Operation
- Request decode, priority order: emergency, or turn_left and turn_right together, selects HAZARD. Otherwise turn_left selects LEFT, turn_right selects RIGHT, and no request selects IDLE.
- Inputs and brake are sampled at every rising edge into registers (brake_q). No combinational path runs from any input to any output.
- Outputs are decoded from the registers state, step, phase and brake_q only.
- Prescaler div counts 0..STEP_DIV-1. tick = (div == STEP_DIV-1). div wraps to 0 on tick and is held at 0 in IDLE.
- State change: when the decoded request differs from state, the next edge loads the new state, clears div, sets step = 1 and sets phase = 1. This restarts the sequence mid-way.
- LEFT: step runs 1, 2, …, LAMPS, 0, 1, … and advances on each tick. left_lamp has its lowest `step` bits set. With LAMPS=3 the pattern is 001, 011, 111, 000, repeating every (LAMPS+1)·STEP_DIV cycles.
- RIGHT: mirror of LEFT on right_lamp, with the same bit order (bit 0 innermost).
- HAZARD: phase toggles on each tick. Both sides drive all-ones when phase = 1 and all-zeros when phase = 0. Brake is ignored in HAZARD.
- IDLE: both sides are 0.
- Brake overlay when brake_q = 1:
  - In IDLE, both sides are all-ones.
  - In LEFT, right_lamp is all-ones and left_lamp continues its sequence.
  - In RIGHT, the overlay mirrors LEFT.
- Brake changes do not restart the sequence and do not disturb step or div.
- Width rules: div is ceil(log2(STEP_DIV)) bits, minimum 1. step is ceil(log2(LAMPS+1)) bits. STEP_DIV = 1 gives a tick every cycle.

## Timing
- Reset value while rst = 1, applied asynchronously: state = IDLE, div = 0, step = 0, phase = 0, brake_q = 0. Outputs are left_lamp = 0, right_lamp = 0, mode = 00.
- Reset asserted mid-sequence clears all outputs immediately, with no clock needed. After rst falls, the first edge samples the inputs.
- Request-to-output latency is 1 cycle. If a request is applied before edge N, mode and the lamps show the new state after edge N; for LEFT the first pattern is 001.
- Each step holds for exactly STEP_DIV cycles, including the first step after entry.
- Brake-to-lamp latency is 1 cycle.
- Requests that pulse for less than one cycle between edges are not seen.
- A request held unchanged never restarts the sequence. The wrap from step LAMPS to step 0 happens on tick with no gap cycle.
- Switching directly from LEFT to RIGHT, or from any state into HAZARD, happens in one edge with no IDLE cycle in between.

## Test plan
All cases use LAMPS=3, STEP_DIV=4 unless noted.
- Reset: assert rst mid-LEFT, asynchronously between edges -> left_lamp, right_lamp and mode are 0 before the next edge. Release rst with no requests -> outputs stay 0.
- Left sequence: hold turn_left -> mode = 01, then left_lamp = 001, 011, 111, 000, 001, each held for 4 cycles, with right_lamp = 000 throughout.
- Hazard priority: turn_left and emergency together -> mode = 11, both sides 111 for 4 cycles then 000 for 4 cycles, repeating. Raising brake changes nothing.
- Brake overlay: hold turn_right and brake -> left_lamp = 111 steady and right_lamp sequences 001, 011, 111, 000. Drop brake mid-step -> left_lamp = 000 after 1 cycle and the right step timing is unchanged.
- Mid-sequence switch: during the LEFT step at 011, assert turn_right only -> next cycle mode = 10, right_lamp = 001, left_lamp = 000, and a fresh 4-cycle step begins.
- Parameter sweep: LAMPS=8, STEP_DIV=1 -> left_lamp advances one bit per cycle from 0x01 to 0xFF, then to 0x00 with a 9-cycle period. Idle with brake -> both sides 0xFF.

Source files
------------

// File: rtl/vlc_tail_seq.sv
// Tail-lamp sequencer: progressive turn sweep, hazard flash and brake overlay
// for LAMPS lamps per side, stepping once every STEP_DIV clocks.
module vlc_tail_seq #(
  parameter int LAMPS    = 3,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             turn_left,
  input  logic             turn_right,
  input  logic             emergency,
  input  logic             brake,
  output logic [LAMPS-1:0] left_lamp,
  output logic [LAMPS-1:0] right_lamp,
  output logic [1:0]       mode
);

  localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int STEP_W = $clog2(LAMPS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LEFT   = 2'b01,
    ST_RIGHT  = 2'b10,
    ST_HAZARD = 2'b11
  } state_t;

  state_t            state_reg, state_next, req;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic              phase_reg, phase_next;
  logic              brake_q;
  logic              tick;
  logic [LAMPS-1:0]  seq_mask;

  assign tick = (div_reg == DIV_LAST);

  always_comb begin
    req = ST_IDLE;
    if (emergency || (turn_left && turn_right)) req = ST_HAZARD;
    else if (turn_left)                          req = ST_LEFT;
    else if (turn_right)                         req = ST_RIGHT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
      step_reg  <= '0;
      phase_reg <= 1'b0;
      brake_q   <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      step_reg  <= step_next;
      phase_reg <= phase_next;
      brake_q   <= brake;
    end
  end

  // A new request restarts the sequence at its first visible step.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    step_next  = step_reg;
    phase_next = phase_reg;
    if (req != state_reg) begin
      state_next = req;
      div_next   = '0;
      step_next  = STEP_W'(1);
      phase_next = 1'b1;
    end else if (state_reg == ST_IDLE) begin
      div_next = '0;
    end else if (tick) begin
      div_next = '0;
      if (state_reg == ST_HAZARD) phase_next = ~phase_reg;
      else step_next = (step_reg == STEP_LAST) ? '0 : step_reg + STEP_W'(1);
    end else begin
      div_next = div_reg + DIV_W'(1);
    end
  end

  // Thermometer of the lowest step_reg lamps.
  generate
    for (genvar gi = 0; gi < LAMPS; gi++) begin : g_mask
      assign seq_mask[gi] = (step_reg > STEP_W'(gi));
    end
  endgenerate

  always_comb begin
    left_lamp  = '0;
    right_lamp = '0;
    case (state_reg)
      ST_IDLE: begin
        left_lamp  = {LAMPS{brake_q}};
        right_lamp = {LAMPS{brake_q}};
      end
      ST_LEFT: begin
        left_lamp  = seq_mask;
        right_lamp = {LAMPS{brake_q}};
      end
      ST_RIGHT: begin
        left_lamp  = {LAMPS{brake_q}};
        right_lamp = seq_mask;
      end
      default: begin
        left_lamp  = {LAMPS{phase_reg}};
        right_lamp = {LAMPS{phase_reg}};
      end
    endcase
  end

  assign mode = state_reg;

endmodule

// File: tb/tb_vlc_tail_seq.sv
// Directed bench for vlc_tail_seq: a per-cycle vector table on a 3-lamp/4-cycle
// instance, plus async reset and an 8-lamp/1-cycle parameter sweep.
module tb_vlc_tail_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       turn_left = 1'b0, turn_right = 1'b0, emergency = 1'b0, brake = 1'b0;
  logic [2:0] left_lamp, right_lamp;
  logic [1:0] mode;
  logic [7:0] left8, right8;
  logic [1:0] mode8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       tl, tr, em, br;
    logic [7:0] l, r;
    logic [1:0] m;
    string      name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  vlc_tail_seq #(.LAMPS(3), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .turn_left(turn_left), .turn_right(turn_right),
    .emergency(emergency), .brake(brake),
    .left_lamp(left_lamp), .right_lamp(right_lamp), .mode(mode)
  );

  vlc_tail_seq #(.LAMPS(8), .STEP_DIV(1)) dut8 (
    .clk(clk), .rst(rst),
    .turn_left(turn_left), .turn_right(turn_right),
    .emergency(emergency), .brake(brake),
    .left_lamp(left8), .right_lamp(right8), .mode(mode8)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic tl, tr, em, br, input logic [7:0] l, r,
                     input logic [1:0] m, input string name);
    vec_t v;
    v.tl = tl; v.tr = tr; v.em = em; v.br = br;
    v.l = l; v.r = r; v.m = m; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic tl, tr, em, br);
    turn_left = tl; turn_right = tr; emergency = em; brake = br;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] lpat[4];
    logic [7:0] sweep[9];
    logic [7:0] e;
    logic       b;
    lpat  = '{8'h01, 8'h03, 8'h07, 8'h00};
    sweep = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    // Per-cycle vectors: inputs held before an edge, outputs expected after it.
    add(0,0,0,0, 8'h0, 8'h0, 2'd0, "idle");
    add(0,0,0,1, 8'h7, 8'h7, 2'd0, "idle_brake");
    add(0,0,0,0, 8'h0, 8'h0, 2'd0, "idle");
    for (int k = 0; k < 17; k++)
      add(1,0,0,0, lpat[(k/4)%4], 8'h0, 2'd1, "left_seq");
    for (int k = 0; k < 12; k++) begin
      e = ((k/4)%2 == 0) ? 8'h7 : 8'h0;
      b = (k >= 4);
      add(1,0,1,b, e, e, 2'd3, "hazard");
    end
    for (int k = 0; k < 17; k++) begin
      b = (k < 6);
      add(0,1,0,b, b ? 8'h7 : 8'h0, lpat[(k/4)%4], 2'd2, "right_brake");
    end
    for (int k = 0; k < 6; k++)
      add(1,0,0,0, lpat[k/4], 8'h0, 2'd1, "left_again");
    for (int k = 0; k < 6; k++)
      add(0,1,0,0, 8'h0, lpat[k/4], 2'd2, "switch_right");
    add(0,0,0,0, 8'h0, 8'h0, 2'd0, "back_idle");

    // Reset state
    cycle();
    check("reset_left", {5'b0, left_lamp}, 8'h0);
    check("reset_right", {5'b0, right_lamp}, 8'h0);
    check("reset_mode", {6'b0, mode}, 8'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].tl, vecs[i].tr, vecs[i].em, vecs[i].br);
      cycle();
      $display("vec %0d %s: left=%h right=%h mode=%0d", i, vecs[i].name,
               left_lamp, right_lamp, mode);
      check({vecs[i].name, "_left"},  {5'b0, left_lamp},  vecs[i].l);
      check({vecs[i].name, "_right"}, {5'b0, right_lamp}, vecs[i].r);
      check({vecs[i].name, "_mode"},  {6'b0, mode},       {6'b0, vecs[i].m});
    end

    // Async reset mid-LEFT, between edges
    drive(1,0,0,0);
    repeat (5) cycle();
    check("pre_rst_left", {5'b0, left_lamp}, 8'h3);
    #1 rst = 1'b1;
    #1;
    $display("async reset: left=%h right=%h mode=%0d", left_lamp, right_lamp, mode);
    check("async_rst_left", {5'b0, left_lamp}, 8'h0);
    check("async_rst_mode", {6'b0, mode}, 8'h0);
    check("async_rst_left8", left8, 8'h0);
    drive(0,0,0,0);
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      $display("post reset %0d: left=%h right=%h mode=%0d", k, left_lamp, right_lamp, mode);
      check("post_rst_left", {5'b0, left_lamp}, 8'h0);
      check("post_rst_right", {5'b0, right_lamp}, 8'h0);
      check("post_rst_mode", {6'b0, mode}, 8'h0);
    end

    // 8 lamps, one step per cycle: 9-cycle period
    drive(1,0,0,0);
    for (int k = 0; k < 12; k++) begin
      cycle();
      $display("sweep %0d: left8=%h right8=%h mode8=%0d", k, left8, right8, mode8);
      check("sweep_left8", left8, sweep[k%9]);
      check("sweep_right8", right8, 8'h00);
      check("sweep_mode8", {6'b0, mode8}, 8'd1);
    end
    drive(0,0,0,1);
    for (int k = 0; k < 2; k++) begin
      cycle();
      $display("idle brake8 %0d: left8=%h right8=%h", k, left8, right8);
      check("idle_brake_left8", left8, 8'hFF);
      check("idle_brake_right8", right8, 8'hFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
